idexe_pipe: RTL and testbench

IDEXE_PIPE -- requirements
Module: idexe_pipe

---
 rtl/idexe_pipe_pkg.sv | 9 +
 rtl/idexe_pipe_sat_counter.sv | 14 +
 rtl/idexe_pipe.sv | 85 ++++++++
 tb/tb_idexe_pipe.sv | 128 ++++++++++++
 4 files changed

// File: rtl/idexe_pipe_pkg.sv
// idexe_pipe_pkg: shared widths, register-0 constant and per-cycle action encoding
package idexe_pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W = 5;
  localparam int DEF_ALUC_W = 4;
  localparam int DEF_CNT_W = 16;
  localparam int REG_ZERO = 0;
  typedef enum logic [2:0] {RESET, FLUSH, HOLD, BUBBLE, LOAD} action_t;
endpackage

// File: rtl/idexe_pipe_sat_counter.sv
// sat_counter: synchronous-clear up-counter that sticks at all-ones
module sat_counter
  import idexe_pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clock)
    cnt <= clear ? '0 : (inc && cnt != '1) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/idexe_pipe.sv
// idexe_pipe: ID/EX pipeline register with load-use hazard bubble, flush, hold and statistics
module idexe_pipe
  import idexe_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int ALUC_W = DEF_ALUC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              ivalid,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              aluimm,
  input  logic [ALUC_W-1:0] aluc,
  input  logic [REG_W-1:0]  destReg,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  input  logic [DATA_W-1:0] imm32,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic              evalid,
  output logic [ALUC_W-1:0] ealuc,
  output logic [REG_W-1:0]  edestReg,
  output logic [DATA_W-1:0] eqa,
  output logic [DATA_W-1:0] eqb,
  output logic [DATA_W-1:0] eimm32,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);
  action_t act;
  always_comb begin
    hazard_stall = evalid & em2reg & (edestReg != REG_W'(REG_ZERO)) & ivalid &
                   ((use_rs & (rs == edestReg)) | (use_rt & (rt == edestReg)));
    act = reset ? RESET : flush ? FLUSH : stall ? HOLD : hazard_stall ? BUBBLE : LOAD;
  end
  always_ff @(posedge clock) begin
    if (act == LOAD) begin
      evalid   <= ivalid;
      ewreg    <= wreg & ivalid;
      ewmem    <= wmem & ivalid;
      em2reg   <= m2reg;
      ealuimm  <= aluimm;
      ealuc    <= aluc;
      edestReg <= destReg;
      eqa      <= qa;
      eqb      <= qb;
      eimm32   <= imm32;
    end else if (act != HOLD) begin
      evalid   <= 1'b0;
      ewreg    <= 1'b0;
      ewmem    <= 1'b0;
      em2reg   <= 1'b0;
      ealuimm  <= 1'b0;
      ealuc    <= '0;
      edestReg <= '0;
      eqa      <= '0;
      eqb      <= '0;
      eimm32   <= '0;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clock(clock),
    .clear(reset),
    .inc  (act == FLUSH || act == BUBBLE),
    .cnt  (bubble_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock(clock),
    .clear(reset),
    .inc  (act == HOLD),
    .cnt  (stall_cnt)
  );
endmodule

// File: tb/tb_idexe_pipe.sv
// tb_idexe_pipe: directed stimulus with queued expectations checked by a negedge monitor
module tb_idexe_pipe;
  typedef struct packed {
    logic        hz;
    logic        ev;
    logic        ew;
    logic        em;
    logic        wm;
    logic        ai;
    logic [3:0]  aluc;
    logic [4:0]  dst;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
    logic [1:0]  bc;
    logic [1:0]  sc;
  } st_t;
  logic clock = 0, reset = 1, flush = 0, stall = 0, ivalid = 0;
  logic wreg = 0, m2reg = 0, wmem = 0, aluimm = 0, use_rs = 0, use_rt = 0;
  logic [3:0] aluc = 0;
  logic [4:0] destReg = 0, rs = 0, rt = 0;
  logic [31:0] qa = 0, qb = 0, imm32 = 0;
  logic ewreg, em2reg, ewmem, ealuimm, evalid, hazard_stall;
  logic [3:0] ealuc;
  logic [4:0] edestReg;
  logic [31:0] eqa, eqb, eimm32;
  logic [1:0] bubble_cnt, stall_cnt;
  st_t exp_q[$];
  string name_q[$];
  int total = 0, bad = 0;
  idexe_pipe #(.CNT_W(2)) dut (
    .clock(clock), .reset(reset), .flush(flush), .stall(stall), .ivalid(ivalid),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .aluc(aluc),
    .destReg(destReg), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
    .qa(qa), .qb(qb), .imm32(imm32), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuimm(ealuimm), .evalid(evalid), .ealuc(ealuc), .edestReg(edestReg),
    .eqa(eqa), .eqb(eqb), .eimm32(eimm32), .hazard_stall(hazard_stall),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    st_t a, w;
    string n;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      n = name_q.pop_front();
      a = {hazard_stall, evalid, ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg,
           eqa, eqb, eimm32, bubble_cnt, stall_cnt};
      total++;
      if (a !== w) begin
        bad++;
        $display("FAIL %s got=%h want=%h", n, a, w);
      end
    end
  end
  task automatic id(input logic iv, w, m, wm, ai, input int al, dst, r_s, u_s, r_t, u_t,
                    input logic [31:0] a, b, im);
    ivalid = iv; wreg = w; m2reg = m; wmem = wm; aluimm = ai; aluc = 4'(al);
    destReg = 5'(dst); rs = 5'(r_s); use_rs = u_s[0]; rt = 5'(r_t); use_rt = u_t[0];
    qa = a; qb = b; imm32 = im;
  endtask
  task automatic chk(input string n, input logic hz, ev, ew, em, wm, ai, input int al, dst,
                     input logic [31:0] a, b, im, input int bc, sc);
    exp_q.push_back({hz, ev, ew, em, wm, ai, 4'(al), 5'(dst), a, b, im, 2'(bc), 2'(sc)});
    name_q.push_back(n);
    @(posedge clock);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    chk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id(1, 1, 0, 0, 0, 2, 3, 0, 0, 0, 0, 32'h11, 32'h22, 32'h4);
    chk("pre_load", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id(1, 1, 1, 0, 0, 0, 5, 0, 0, 0, 0, 32'h33, 0, 0);
    chk("load", 0, 1, 1, 0, 0, 0, 2, 3, 32'h11, 32'h22, 32'h4, 0, 0);
    id(1, 1, 0, 0, 0, 0, 6, 5, 1, 0, 0, 32'h44, 0, 0);
    chk("load_use", 1, 1, 1, 1, 0, 0, 0, 5, 32'h33, 0, 0, 0, 0);
    chk("bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    id(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77, 0, 0);
    chk("after_bubble", 0, 1, 1, 0, 0, 0, 0, 6, 32'h44, 0, 0, 1, 0);
    id(1, 1, 0, 0, 0, 0, 7, 0, 1, 0, 1, 32'h88, 0, 0);
    chk("reg0", 0, 1, 1, 1, 0, 0, 0, 0, 32'h77, 0, 0, 1, 0);
    stall = 1;
    id(1, 1, 0, 0, 0, 0, 9, 0, 0, 0, 0, 32'h99, 0, 0);
    chk("reg0_load", 0, 1, 1, 0, 0, 0, 0, 7, 32'h88, 0, 0, 1, 0);
    qa = 32'haa;
    chk("stall1", 0, 1, 1, 0, 0, 0, 0, 7, 32'h88, 0, 0, 1, 1);
    qa = 32'hbb;
    chk("stall2", 0, 1, 1, 0, 0, 0, 0, 7, 32'h88, 0, 0, 1, 2);
    flush = 1;
    chk("stall3", 0, 1, 1, 0, 0, 0, 0, 7, 32'h88, 0, 0, 1, 3);
    flush = 0;
    stall = 0;
    id(0, 1, 1, 1, 1, 3, 10, 0, 0, 0, 0, 32'hcc, 0, 0);
    chk("flush_stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3);
    flush = 1;
    chk("invalid_load", 0, 0, 0, 1, 0, 1, 3, 10, 32'hcc, 0, 0, 2, 3);
    chk("flush_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    chk("bc_sat", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    flush = 0;
    id(1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 32'h55, 0, 0);
    chk("bc_sat2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    stall = 1;
    chk("load55", 0, 1, 1, 0, 0, 0, 0, 2, 32'h55, 0, 0, 3, 3);
    reset = 1;
    chk("held55", 0, 1, 1, 0, 0, 0, 0, 2, 32'h55, 0, 0, 3, 3);
    reset = 0;
    stall = 0;
    id(1, 1, 1, 0, 0, 0, 4, 0, 0, 0, 0, 32'h66, 0, 0);
    chk("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1;
    id(1, 1, 0, 0, 0, 0, 8, 0, 0, 4, 1, 32'h70, 0, 0);
    chk("post_reset", 1, 1, 1, 1, 0, 0, 0, 4, 32'h66, 0, 0, 0, 0);
    stall = 0;
    chk("hz_held", 1, 1, 1, 1, 0, 0, 0, 4, 32'h66, 0, 0, 0, 1);
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rt_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (2) @(posedge clock);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
